// File: rtl/uart_frame_ctrl.sv
// UART upload sequencer: parses a 0x00-led image header and streams the pixel
// bytes into the frame buffer. Every other byte is forwarded as a command.
module uart_frame_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        cmd_out,
    output logic              cmd_valid,
    output logic              pix_en,
    output logic [7:0]        img_vres,
    output logic [7:0]        img_hres,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR_V  = 2'd1,
        HDR_H  = 2'd2,
        PIXELS = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idle_cnt, idle_cnt_d;
    logic [ADDR_W-1:0]  pix_cnt, pix_cnt_d;
    logic [ADDR_W-1:0]  total, total_d;
    logic [15:0]        res_prod;
    logic               timeout;

    logic [7:0]         cmd_out_d;
    logic               cmd_valid_d;
    logic               pix_en_d;
    logic [7:0]         img_vres_d;
    logic [7:0]         img_hres_d;
    logic               fb_we_d;
    logic [ADDR_W-1:0]  fb_addr_d;
    logic [7:0]         fb_wdata_d;
    logic               frame_done_d;
    logic               frame_err_d;

    assign res_prod = {8'h00, img_vres} * {8'h00, rx_data};

    // Abort fires on the cycle in which the idle count would step onto
    // TIMEOUT_CYC-1; a byte arriving in that cycle still takes priority.
    assign timeout = (state_q != IDLE) && !rx_valid &&
                     (idle_cnt == CNT_W'(TIMEOUT_CYC - 2));

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt + CNT_W'(1);
        pix_cnt_d    = pix_cnt;
        total_d      = total;
        cmd_out_d    = cmd_out;
        cmd_valid_d  = 1'b0;
        img_vres_d   = img_vres;
        img_hres_d   = img_hres;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr;
        fb_wdata_d   = fb_wdata;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || rx_valid) begin
            idle_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h00) begin
                        state_d = HDR_V;
                    end else begin
                        cmd_out_d   = rx_data;
                        cmd_valid_d = 1'b1;
                    end
                end
            end
            HDR_V: begin
                if (rx_valid) begin
                    img_vres_d = rx_data;
                    if (rx_data == 8'h00) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = HDR_H;
                    end
                end
            end
            HDR_H: begin
                if (rx_valid) begin
                    img_hres_d = rx_data;
                    if (rx_data == 8'h00) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        pix_cnt_d = '0;
                        total_d   = ADDR_W'(res_prod);
                        state_d   = PIXELS;
                    end
                end
            end
            PIXELS: begin
                if (rx_valid) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = pix_cnt;
                    fb_wdata_d = rx_data;
                    pix_cnt_d  = pix_cnt + ADDR_W'(1);
                    if (pix_cnt == total - ADDR_W'(1)) begin
                        frame_done_d = 1'b1;
                        pix_cnt_d    = '0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            frame_err_d = 1'b1;
            pix_cnt_d   = '0;
            state_d     = IDLE;
        end

        pix_en_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idle_cnt   <= '0;
            pix_cnt    <= '0;
            total      <= '0;
            cmd_out    <= '0;
            cmd_valid  <= 1'b0;
            pix_en     <= 1'b0;
            img_vres   <= '0;
            img_hres   <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt   <= idle_cnt_d;
            pix_cnt    <= pix_cnt_d;
            total      <= total_d;
            cmd_out    <= cmd_out_d;
            cmd_valid  <= cmd_valid_d;
            pix_en     <= pix_en_d;
            img_vres   <= img_vres_d;
            img_hres   <= img_hres_d;
            fb_we      <= fb_we_d;
            fb_addr    <= fb_addr_d;
            fb_wdata   <= fb_wdata_d;
            frame_done <= frame_done_d;
            frame_err  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: a byte-level model queues the expected
// output pulses (with their cycle) as bytes are sent; a monitor pops and compares.
module tb_uart_frame_ctrl;

    localparam int ADDR_W = 16;
    localparam int TO_CYC = 16;

    localparam logic [1:0] EV_CMD  = 2'd0;
    localparam logic [1:0] EV_WR   = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        cmd_out;
    logic              cmd_valid;
    logic              pix_en;
    logic [7:0]        img_vres;
    logic [7:0]        img_hres;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_wdata;
    logic              frame_done;
    logic              frame_err;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_rx_cyc = 0;

    // byte-level reference model state
    int unsigned m_state = 0;
    int unsigned m_vres = 0;
    int unsigned m_total = 0;
    int unsigned m_cnt = 0;

    uart_frame_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .pix_en    (pix_en),
        .img_vres  (img_vres),
        .img_hres  (img_hres),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input logic [1:0] kind, input int unsigned addr,
                                    input logic [7:0] data, input logic [31:0] at);
        ev_t e;
        e.kind = kind;
        e.addr = addr[15:0];
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    // Called at a falling edge; presents the byte for exactly one rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_rx_cyc = cyc;
        case (m_state)
            0: if (b == 8'h00) m_state = 1;
               else push_ev(EV_CMD, 0, b, cyc + 1);
            1: begin
                m_vres = b;
                if (b == 8'h00) begin
                    push_ev(EV_ERR, 0, 8'h00, cyc + 1);
                    m_state = 0;
                end else m_state = 2;
            end
            2: begin
                if (b == 8'h00) begin
                    push_ev(EV_ERR, 0, 8'h00, cyc + 1);
                    m_state = 0;
                end else begin
                    m_total = m_vres * b;
                    m_cnt   = 0;
                    m_state = 3;
                end
            end
            default: begin
                if (m_cnt == m_total - 1) begin
                    push_ev(EV_DONE, m_cnt, b, cyc + 1);
                    m_state = 0;
                end else push_ev(EV_WR, m_cnt, b, cyc + 1);
                m_cnt++;
            end
        endcase
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_cmd_out"}, 32'(cmd_out), 0);
        check_eq({tag, "_pulses"}, 32'({cmd_valid, fb_we, frame_done, frame_err}), 0);
        check_eq({tag, "_pix_en"}, 32'(pix_en), 0);
        check_eq({tag, "_res"}, 32'({img_vres, img_hres}), 0);
        check_eq({tag, "_fb_addr"}, 32'(fb_addr), 0);
        check_eq({tag, "_fb_wdata"}, 32'(fb_wdata), 0);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(posedge CLK) begin
        #1;
        if (cmd_valid || fb_we || frame_done || frame_err) begin
            logic [1:0] kind;
            ev_t e;
            kind = cmd_valid ? EV_CMD : frame_err ? EV_ERR : frame_done ? EV_DONE : EV_WR;
            check_eq("done_err_excl", 32'(frame_done & frame_err), 0);
            check_eq("done_needs_we", 32'(frame_done & ~fb_we), 0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", 32'({cmd_valid, fb_we, frame_done, frame_err}), 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("ev_kind", 32'(kind), 32'(e.kind));
                check_eq("ev_cycle", cyc, e.cyc);
                if (e.kind == EV_CMD) begin
                    check_eq("cmd_out", 32'(cmd_out), 32'(e.data));
                    check_eq("cmd_no_we", 32'(fb_we), 0);
                end else if (e.kind != EV_ERR) begin
                    check_eq("fb_addr", 32'(fb_addr), 32'(e.addr));
                    check_eq("fb_wdata", 32'(fb_wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        idle(3);
        check_zero_outputs("reset");
        RST = 1'b0;
        idle(2);

        // plain commands
        send(8'h41);
        send(8'h07);
        idle(2);
        check_eq("cmd_pix_en", 32'(pix_en), 0);
        check_eq("cmd_hold", 32'(cmd_out), 32'h07);

        // 2x3 frame, back-to-back pixels
        send(8'h00);
        check_eq("pix_en_rise", 32'(pix_en), 1);
        send(8'h02);
        send(8'h03);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        check_eq("pix_en_mid", 32'(pix_en), 1);
        send(8'h15);
        check_eq("pix_en_fall", 32'(pix_en), 0);
        check_eq("vres_2x3", 32'(img_vres), 2);
        check_eq("hres_2x3", 32'(img_hres), 3);

        // new frame right after frame_done; 0x00/0xFF are pixels
        send(8'h00);
        send(8'h01);
        send(8'h02);
        send(8'h00);
        send(8'hFF);
        idle(2);
        check_eq("res_1x2", 32'({img_vres, img_hres}), 32'h0102);

        // zero vertical resolution aborts
        send(8'h00);
        send(8'h00);
        check_eq("zero_res_pix_en", 32'(pix_en), 0);
        send(8'h33);
        idle(2);
        check_eq("zero_vres_latched", 32'(img_vres), 0);
        check_eq("hres_held", 32'(img_hres), 2);

        // timeout after 3 pixels of a 4x4 frame
        send(8'h00);
        send(8'h04);
        send(8'h04);
        send(8'hA0);
        send(8'hA1);
        send(8'hA2);
        push_ev(EV_ERR, 0, 8'h00, last_rx_cyc + TO_CYC);
        m_state = 0;
        idle(TO_CYC + 4);
        check_eq("timeout_pix_en", 32'(pix_en), 0);
        send(8'h00);
        send(8'h01);
        send(8'h01);
        send(8'h77);
        idle(2);

        // reset in the middle of a 255x255 upload
        send(8'h00);
        send(8'hFF);
        send(8'hFF);
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i));
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        m_state = 0;
        check_zero_outputs("midreset");
        idle(TO_CYC + 4);
        send(8'h00);
        send(8'h01);
        send(8'h01);
        send(8'hAA);
        idle(3);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
